// File: rtl/jpeg_mcu_sequencer.sv
// Stage sequencer for the JPEG encode pipeline: steps each 8x8 block of an MCU through load, DCT,
// quantize/zigzag, DC prediction and Huffman. Define JPEG_SEQ_RESTART_EN to add restart-interval support.
module jpeg_mcu_sequencer #(
   parameter int NUM_COMP   = 3,
   parameter int Y_BLOCKS   = 1,
   parameter int DCT_CYCLES = 8,
   parameter int DC_WIDTH   = 12
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       blk_valid,
   output logic                       blk_ready,
   output logic                       input_enable,
   output logic                       dct_enable,
   output logic                       dct_end_enable,
   output logic [7:0]                 matrix_row,
   output logic                       zigzag_input_enable,
   output logic                       zigzag_enable,
   input  logic signed [DC_WIDTH-1:0] dc_coeff,
   output logic signed [DC_WIDTH:0]   dc_diff,
   output logic                       dc_diff_valid,
   output logic                       huffman_start,
   input  logic                       huffman_done,
   output logic                       is_luminance,
   output logic [1:0]                 comp_id,
   output logic                       mcu_done,
   output logic                       busy
`ifdef JPEG_SEQ_RESTART_EN
   ,
   input  logic [15:0]                restart_interval,
   output logic                       restart_pulse
`endif
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DCT,
      ST_DCTEND,
      ST_QZ,
      ST_ZZ,
      ST_DCDIFF,
      ST_HUFF,
      ST_NEXT
   } state_t;

   localparam int         CNT_W    = (DCT_CYCLES > 1) ? $clog2(DCT_CYCLES) : 1;
   localparam logic [2:0] LAST_IDX = 3'(Y_BLOCKS + NUM_COMP - 2);
   localparam logic [2:0] LAST_Y   = 3'(Y_BLOCKS - 1);

   state_t                      state;
   logic [CNT_W-1:0]            dct_count;
   logic [2:0]                  blk_idx;
   logic signed [DC_WIDTH-1:0]  pred [4];
   logic signed [DC_WIDTH:0]    dc_wide;
   logic signed [DC_WIDTH:0]    pred_wide;
`ifdef JPEG_SEQ_RESTART_EN
   logic [15:0]                 mcu_count;
`endif

   // The luma blocks come first, then one block per chroma component.
   assign comp_id      = (blk_idx > LAST_Y) ? 2'(blk_idx - LAST_Y) : 2'd0;
   assign is_luminance = (comp_id == 2'd0);

   assign dc_wide   = {dc_coeff[DC_WIDTH-1], dc_coeff};
   assign pred_wide = {pred[comp_id][DC_WIDTH-1], pred[comp_id]};
   assign dc_diff   = (state == ST_DCDIFF) ? (dc_wide - pred_wide) : '0;

   // Strobes are registered on entry to the state that owns them, so each is cleared by default.
   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= ST_IDLE;
         dct_count           <= '0;
         blk_idx             <= '0;
         blk_ready           <= 1'b1;
         busy                <= 1'b0;
         input_enable        <= 1'b0;
         dct_enable          <= 1'b0;
         dct_end_enable      <= 1'b0;
         matrix_row          <= 8'd0;
         zigzag_input_enable <= 1'b0;
         zigzag_enable       <= 1'b0;
         dc_diff_valid       <= 1'b0;
         huffman_start       <= 1'b0;
         mcu_done            <= 1'b0;
         for (int i = 0; i < 4; i++) pred[i] <= '0;
`ifdef JPEG_SEQ_RESTART_EN
         mcu_count           <= 16'd0;
         restart_pulse       <= 1'b0;
`endif
      end else begin
         input_enable        <= 1'b0;
         dct_enable          <= 1'b0;
         dct_end_enable      <= 1'b0;
         matrix_row          <= 8'd0;
         zigzag_input_enable <= 1'b0;
         zigzag_enable       <= 1'b0;
         dc_diff_valid       <= 1'b0;
         huffman_start       <= 1'b0;
         mcu_done            <= 1'b0;
`ifdef JPEG_SEQ_RESTART_EN
         restart_pulse       <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (blk_valid) begin
                  state        <= ST_LOAD;
                  input_enable <= 1'b1;
                  blk_ready    <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            ST_LOAD: begin
               state      <= ST_DCT;
               dct_enable <= 1'b1;
               dct_count  <= CNT_W'(DCT_CYCLES - 1);
            end
            ST_DCT: begin
               if (dct_count == '0) begin
                  state          <= ST_DCTEND;
                  dct_end_enable <= 1'b1;
               end else begin
                  dct_count  <= dct_count - CNT_W'(1);
                  dct_enable <= 1'b1;
               end
            end
            ST_DCTEND: begin
               state               <= ST_QZ;
               zigzag_input_enable <= 1'b1;
            end
            ST_QZ: begin
               if (matrix_row == 8'd7) begin
                  state         <= ST_ZZ;
                  zigzag_enable <= 1'b1;
               end else begin
                  matrix_row          <= matrix_row + 8'd1;
                  zigzag_input_enable <= 1'b1;
               end
            end
            ST_ZZ: begin
               state         <= ST_DCDIFF;
               dc_diff_valid <= 1'b1;
            end
            ST_DCDIFF: begin
               pred[comp_id] <= dc_coeff;
               state         <= ST_HUFF;
               huffman_start <= 1'b1;
            end
            ST_HUFF: begin
               // huffman_start doubles as the first-cycle flag, so a done on that cycle is ignored.
               if (!huffman_start && huffman_done) begin
                  state    <= ST_NEXT;
                  mcu_done <= (blk_idx == LAST_IDX);
`ifdef JPEG_SEQ_RESTART_EN
                  if (blk_idx == LAST_IDX) begin
                     if ((restart_interval != 16'd0) && ((mcu_count + 16'd1) == restart_interval)) begin
                        mcu_count     <= 16'd0;
                        restart_pulse <= 1'b1;
                        for (int i = 0; i < 4; i++) pred[i] <= '0;
                     end else begin
                        mcu_count <= mcu_count + 16'd1;
                     end
                  end
`endif
               end
            end
            ST_NEXT: begin
               state     <= ST_IDLE;
               blk_ready <= 1'b1;
               busy      <= 1'b0;
               blk_idx   <= (blk_idx == LAST_IDX) ? 3'd0 : blk_idx + 3'd1;
            end
            default: begin
               state     <= ST_IDLE;
               blk_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/jpeg_mcu_sequencer.md
# jpeg_mcu_sequencer

- Parametrised stage sequencer for the JPEG encode pipeline. It drives the buffer load, DCT, quantize/zigzag and Huffman strobes for every 8x8 block of a multi-component MCU.
- Supports configurable luma blocks per MCU (4:4:4, 4:2:2, 4:2:0) and per-component ordering.
- Keeps one DC predictor per component and emits the DC difference before Huffman encoding.
- Sits between the block source and the existing datapath instances, replacing the external strobe generation.

## Interface
- NUM_COMP, 3, number of colour components per MCU (1..4); component 0 is luminance
- Y_BLOCKS, 1, luminance blocks per MCU (1, 2 or 4)
- DCT_CYCLES, 8, cycles `dct_enable` is held per block (>=1)
- DC_WIDTH, 12, signed width of the quantized DC coefficient
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- blk_valid  in  1  source has a full 8x8 block on the pixel bus
- blk_ready  out  1  sequencer accepts a block (high only in IDLE)
- input_enable  out  1  one-cycle load strobe to the input buffer
- dct_enable  out  1  DCT run strobe
- dct_end_enable  out  1  one-cycle capture strobe to the DCT result buffer
- matrix_row  out  8  quantize/zigzag row index 0..7
- zigzag_input_enable  out  1  zigzag row write strobe
- zigzag_enable  out  1  one-cycle zigzag reorder strobe
- dc_coeff  in  DC_WIDTH  signed quantized DC of the current block; valid in DCDIFF
- dc_diff  out  DC_WIDTH+1  signed dc_coeff minus the predictor of the current component
- dc_diff_valid  out  1  one-cycle qualifier for `dc_diff`
- huffman_start  out  1  one-cycle Huffman controller start
- huffman_done  in  1  Huffman controller finished the block
- is_luminance  out  1  high when comp_id == 0
- comp_id  out  2  component of the block in flight
- mcu_done  out  1  one-cycle pulse after the last block of an MCU
- busy  out  1  high in every state except IDLE

## Operation
- **States:** IDLE, LOAD, DCT, DCTEND, QZ, ZZ, DCDIFF, HUFF, NEXT.
- **IDLE:** `blk_ready`=1. When `blk_valid`=1, go to LOAD.
- **LOAD:** `input_enable`=1 for 1 cycle, then DCT.
- **DCT:** `dct_enable`=1 for DCT_CYCLES cycles, counted by a down-counter, then DCTEND.
- **DCTEND:** `dct_end_enable`=1 for 1 cycle, then QZ.
- **QZ:** 8 cycles; `matrix_row` counts 0..7 and `zigzag_input_enable`=1 throughout. After row 7, go to ZZ.
- **ZZ:** `zigzag_enable`=1 for 1 cycle, then DCDIFF.
- **DCDIFF:** 1 cycle.
  - `dc_diff` = sign-extended `dc_coeff` minus `pred[comp_id]`, computed at full DC_WIDTH+1 width with no saturation.
  - `dc_diff_valid`=1.
  - `pred[comp_id]` <= `dc_coeff` at the end of the cycle.
- **HUFF:** `huffman_start`=1 on the first cycle only. Then wait for `huffman_done`.
  - `huffman_done` is sampled from the second HUFF cycle onward.
  - `huffman_done` in any other state is ignored.
- **NEXT:** 1 cycle; advances the block index.
  - If the block was the last of the MCU: `mcu_done`=1 and the block index wraps to 0.
  - Then return to IDLE.
- **Block order within an MCU:** Y_BLOCKS blocks with comp_id=0, then one block each for comp_id 1..NUM_COMP-1. MCU length is Y_BLOCKS+NUM_COMP-1 blocks.
- **Strobe exclusivity:** only the strobe of the current state is asserted; all others are 0.
- **`matrix_row`:** 0 outside QZ.
- **`comp_id` / `is_luminance`:** reflect the block index in every state, including IDLE (the next block to be accepted).

## Timing
- **Reset values:** all strobes, `dc_diff`, `dc_diff_valid` and `mcu_done` = 0; `matrix_row`=0; `comp_id`=0; `is_luminance`=1; `busy`=0; `blk_ready`=1 from the first cycle after reset. All predictors and the block index are cleared.
- **Latency:** `blk_valid` sampled in IDLE -> `input_enable` on the next cycle.
- **Huffman start:** LOAD to `huffman_start` is 1+DCT_CYCLES+1+8+1+1 cycles (20 with defaults).
- **Block turnaround:** `huffman_done` -> NEXT on the next cycle -> IDLE one cycle later, so `blk_ready` rises 2 cycles after `huffman_done`.
- **Reset mid-operation:** reset has priority over all state transitions. It returns the block to IDLE, clears predictors and block index, and drops every strobe in the same edge.
- **Simultaneous `huffman_done` and `huffman_start`:** `huffman_done` on the start cycle is ignored.

## Configuration
- **JPEG_SEQ_RESTART_EN defined:**
  - Adds input `restart_interval` [15:0] and output `restart_pulse` [1].
  - An MCU counter increments on each `mcu_done`.
  - When the count reaches `restart_interval` (and `restart_interval` is nonzero), in the same NEXT cycle: all predictors clear, the counter clears and `restart_pulse`=1 for one cycle.
  - `restart_interval`=0 disables restarts.
- **JPEG_SEQ_RESTART_EN undefined:** no extra ports; predictors clear only on reset.

## Test plan
- **Single-component block:** NUM_COMP=1, Y_BLOCKS=1, `blk_valid` held high, `huffman_done` 5 cycles after start.
  - `input_enable` at cycle 1, `dct_enable` cycles 2-9, `dct_end_enable` 10, `matrix_row` 0..7 on cycles 11-18, `zigzag_enable` 19, `huffman_start` 21, `mcu_done` every block.
- **4:2:0 ordering:** NUM_COMP=3, Y_BLOCKS=4, 12 blocks.
  - comp_id sequence 0,0,0,0,1,2 repeated twice.
  - `is_luminance` high on exactly the comp 0 blocks.
  - `mcu_done` after the 6th and 12th blocks.
- **DC prediction:** comp 0 DC values 100, 95, -2048.
  - `dc_diff` = 100, -5, -2143; the last value needs 13 bits and must not wrap.
- **Reset mid-block:** assert reset during QZ row 4, then send a block with DC=7.
  - All outputs reach their reset values next cycle; the new block starts at comp 0 and `dc_diff`=7.
- **Handshake:** `blk_valid` pulsed during HUFF is ignored.
  - A spurious `huffman_done` in DCT causes no state change.
  - `blk_ready` rises exactly 2 cycles after `huffman_done`.
- **Restarts (with JPEG_SEQ_RESTART_EN):** `restart_interval`=2, NUM_COMP=1, DC values 10, 12, 15.
  - `dc_diff` = 10, 2, 15.
  - `restart_pulse` coincides with the 2nd `mcu_done`.
